// File: rtl/mem_ctrl.sv
// mem_ctrl_pkg: shared request/response types for the cache-to-memory protocol.
package mem_ctrl_pkg;

  localparam int unsigned BLOCK_W         = 64;
  localparam int unsigned MAIN_MEM_ADDR_W = 32;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } req_type_t;

  typedef logic [MAIN_MEM_ADDR_W-1:0] main_mem_block_addr_t;
  typedef logic [BLOCK_W-1:0]         block_data_t;

  // One pending request slot payload.
  typedef struct packed {
    req_type_t            req_type;
    main_mem_block_addr_t addr;
    block_data_t          data;
  } mem_req_t;

endpackage

// mem_ctrl: memory-side responder for the icache and dcache.
// Holds one request slot per cache, arbitrates with fixed icache priority,
// services each granted request against a block-addressed memory after
// MEM_LATENCY cycles and returns a single-cycle response pulse.
// Ports:
//   clk, rst_aL                  clock, synchronous active-low reset
//   icache_req_*                 icache request (READ only), ready = slot empty
//   dcache_req_*                 dcache request (READ/WRITE), ready = slot empty
//   icache_resp_*, dcache_resp_* one-cycle response pulse with block data
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned N_BLOCKS    = 1024,
  parameter int unsigned MEM_LATENCY = 10
) (
  input  logic                 clk,
  input  logic                 rst_aL,

  input  logic                 icache_req_valid,
  input  req_type_t            icache_req_type,
  input  main_mem_block_addr_t icache_req_block_addr,
  input  block_data_t          icache_req_block_data,
  output logic                 icache_req_ready,

  input  logic                 dcache_req_valid,
  input  req_type_t            dcache_req_type,
  input  main_mem_block_addr_t dcache_req_block_addr,
  input  block_data_t          dcache_req_block_data,
  output logic                 dcache_req_ready,

  output logic                 icache_resp_valid,
  output block_data_t          icache_resp_block_data,
  output logic                 dcache_resp_valid,
  output block_data_t          dcache_resp_block_data
);

  localparam int unsigned IDX_W = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1;
  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  state_t            state_q,        state_d;
  logic [CNT_W-1:0]  cnt_q,          cnt_d;
  port_t             grant_q,        grant_d;
  logic              i_pend_q,       i_pend_d;
  mem_req_t          i_slot_q,       i_slot_d;
  logic              d_pend_q,       d_pend_d;
  mem_req_t          d_slot_q,       d_slot_d;
  logic              i_resp_valid_q, i_resp_valid_d;
  block_data_t       i_resp_data_q,  i_resp_data_d;
  logic              d_resp_valid_q, d_resp_valid_d;
  block_data_t       d_resp_data_q,  d_resp_data_d;

  block_data_t       mem [N_BLOCKS];

  mem_req_t          sel_slot_c;
  logic [IDX_W-1:0]  mem_idx_c;
  logic              commit_c;
  logic              mem_we_c;
  block_data_t       resp_data_c;
  logic              i_clear_c;
  logic              d_clear_c;
  logic              i_accept_c;
  logic              d_accept_c;
  logic              unused_ok;

  // Slot currently owning the memory; only meaningful in BUSY/RESP.
  assign sel_slot_c  = (grant_q == PORT_I) ? i_slot_q : d_slot_q;
  assign mem_idx_c   = sel_slot_c.addr[IDX_W-1:0];
  assign commit_c    = (state_q == ST_BUSY) && (cnt_q == '0);
  assign mem_we_c    = commit_c && (sel_slot_c.req_type == WRITE);
  assign resp_data_c = (sel_slot_c.req_type == WRITE) ? sel_slot_c.data : mem[mem_idx_c];

  // A slot frees on the RESP->IDLE edge, so a new request can land on that same edge.
  assign i_clear_c  = (state_q == ST_RESP) && (grant_q == PORT_I);
  assign d_clear_c  = (state_q == ST_RESP) && (grant_q == PORT_D);
  assign i_accept_c = icache_req_valid && (!i_pend_q || i_clear_c);
  assign d_accept_c = dcache_req_valid && (!d_pend_q || d_clear_c);

  assign icache_req_ready = rst_aL & ~i_pend_q;
  assign dcache_req_ready = rst_aL & ~d_pend_q;

  assign icache_resp_valid      = i_resp_valid_q;
  assign icache_resp_block_data = i_resp_data_q;
  assign dcache_resp_valid      = d_resp_valid_q;
  assign dcache_resp_block_data = d_resp_data_q;

  // Upper address bits and icache write data carry no information here.
  assign unused_ok = ^{icache_req_block_data, icache_req_type, sel_slot_c};

  // Next-state, slot bookkeeping and response generation.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    grant_d        = grant_q;
    i_pend_d       = i_pend_q;
    i_slot_d       = i_slot_q;
    d_pend_d       = d_pend_q;
    d_slot_d       = d_slot_q;
    i_resp_valid_d = 1'b0;
    i_resp_data_d  = '0;
    d_resp_valid_d = 1'b0;
    d_resp_data_d  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_pend_q) begin
          state_d = ST_BUSY;
          grant_d = PORT_I;
          cnt_d   = CNT_LOAD;
        end else if (d_pend_q) begin
          state_d = ST_BUSY;
          grant_d = PORT_D;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          if (grant_q == PORT_I) begin
            i_resp_valid_d = 1'b1;
            i_resp_data_d  = resp_data_c;
          end else begin
            d_resp_valid_d = 1'b1;
            d_resp_data_d  = resp_data_c;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (i_clear_c) begin
      i_pend_d = 1'b0;
    end
    if (d_clear_c) begin
      d_pend_d = 1'b0;
    end

    // icache is read-only; a stray WRITE is captured as a READ.
    if (i_accept_c) begin
      i_pend_d          = 1'b1;
      i_slot_d.req_type = READ;
      i_slot_d.addr     = icache_req_block_addr;
      i_slot_d.data     = '0;
    end
    if (d_accept_c) begin
      d_pend_d          = 1'b1;
      d_slot_d.req_type = dcache_req_type;
      d_slot_d.addr     = dcache_req_block_addr;
      d_slot_d.data     = dcache_req_block_data;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      grant_q        <= PORT_I;
      i_pend_q       <= 1'b0;
      i_slot_q       <= '0;
      d_pend_q       <= 1'b0;
      d_slot_q       <= '0;
      i_resp_valid_q <= 1'b0;
      i_resp_data_q  <= '0;
      d_resp_valid_q <= 1'b0;
      d_resp_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      grant_q        <= grant_d;
      i_pend_q       <= i_pend_d;
      i_slot_q       <= i_slot_d;
      d_pend_q       <= d_pend_d;
      d_slot_q       <= d_slot_d;
      i_resp_valid_q <= i_resp_valid_d;
      i_resp_data_q  <= i_resp_data_d;
      d_resp_valid_q <= d_resp_valid_d;
      d_resp_data_q  <= d_resp_data_d;
    end
  end

  // Memory array keeps its contents through reset; a write still in flight
  // when reset hits is dropped.
  always_ff @(posedge clk) begin
    if (rst_aL && mem_we_c) begin
      mem[mem_idx_c] <= sel_slot_c.data;
    end
  end

  // Flag an icache WRITE at acceptance.
  always_ff @(posedge clk) begin
    if (rst_aL && i_accept_c) begin
      assert (icache_req_type == READ)
        else $error("mem_ctrl: icache WRITE request, serviced as READ");
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int unsigned L  = 10;
  localparam int unsigned NB = 1024;
  localparam int unsigned SL = 1;
  localparam int unsigned SN = 16;

  logic clk    = 1'b0;
  logic rst_aL = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default parameters)
  logic                 icache_req_valid;
  req_type_t            icache_req_type;
  main_mem_block_addr_t icache_req_block_addr;
  block_data_t          icache_req_block_data;
  logic                 icache_req_ready;
  logic                 dcache_req_valid;
  req_type_t            dcache_req_type;
  main_mem_block_addr_t dcache_req_block_addr;
  block_data_t          dcache_req_block_data;
  logic                 dcache_req_ready;
  logic                 icache_resp_valid;
  block_data_t          icache_resp_block_data;
  logic                 dcache_resp_valid;
  block_data_t          dcache_resp_block_data;

  // Small instance (L=1, 16 blocks)
  logic                 s_icache_req_valid;
  req_type_t            s_icache_req_type;
  main_mem_block_addr_t s_icache_req_block_addr;
  block_data_t          s_icache_req_block_data;
  logic                 s_icache_req_ready;
  logic                 s_dcache_req_valid;
  req_type_t            s_dcache_req_type;
  main_mem_block_addr_t s_dcache_req_block_addr;
  block_data_t          s_dcache_req_block_data;
  logic                 s_dcache_req_ready;
  logic                 s_icache_resp_valid;
  block_data_t          s_icache_resp_block_data;
  logic                 s_dcache_resp_valid;
  block_data_t          s_dcache_resp_block_data;

  mem_ctrl #(.N_BLOCKS(NB), .MEM_LATENCY(L)) u_dut (
    .clk                    (clk),
    .rst_aL                 (rst_aL),
    .icache_req_valid       (icache_req_valid),
    .icache_req_type        (icache_req_type),
    .icache_req_block_addr  (icache_req_block_addr),
    .icache_req_block_data  (icache_req_block_data),
    .icache_req_ready       (icache_req_ready),
    .dcache_req_valid       (dcache_req_valid),
    .dcache_req_type        (dcache_req_type),
    .dcache_req_block_addr  (dcache_req_block_addr),
    .dcache_req_block_data  (dcache_req_block_data),
    .dcache_req_ready       (dcache_req_ready),
    .icache_resp_valid      (icache_resp_valid),
    .icache_resp_block_data (icache_resp_block_data),
    .dcache_resp_valid      (dcache_resp_valid),
    .dcache_resp_block_data (dcache_resp_block_data)
  );

  mem_ctrl #(.N_BLOCKS(SN), .MEM_LATENCY(SL)) u_sml (
    .clk                    (clk),
    .rst_aL                 (rst_aL),
    .icache_req_valid       (s_icache_req_valid),
    .icache_req_type        (s_icache_req_type),
    .icache_req_block_addr  (s_icache_req_block_addr),
    .icache_req_block_data  (s_icache_req_block_data),
    .icache_req_ready       (s_icache_req_ready),
    .dcache_req_valid       (s_dcache_req_valid),
    .dcache_req_type        (s_dcache_req_type),
    .dcache_req_block_addr  (s_dcache_req_block_addr),
    .dcache_req_block_data  (s_dcache_req_block_data),
    .dcache_req_ready       (s_dcache_req_ready),
    .icache_resp_valid      (s_icache_resp_valid),
    .icache_resp_block_data (s_icache_resp_block_data),
    .dcache_resp_valid      (s_dcache_resp_valid),
    .dcache_resp_block_data (s_dcache_resp_block_data)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction-level reference for the main instance: each port holds one
  // request; a free controller starts the oldest-eligible request (icache
  // first) no earlier than one edge after acceptance, answers L edges later,
  // and can start the next one two edges after answering.
  bit          m_v    [2];
  bit          m_wr   [2];
  logic [31:0] m_addr [2];
  logic [63:0] m_data [2];
  bit          m_busy      = 1'b0;
  int          m_port      = 0;
  int          m_resp      = 0;
  int          m_free      = 0;
  logic [63:0] m_mem   [NB];
  bit          m_known [NB];
  int          m_exp_port  = -1;
  logic [63:0] m_exp_data  = '0;
  bit          m_exp_known = 1'b0;

  task automatic model_step();
    int idx;
    m_exp_port = -1;
    if (!rst_aL) begin
      m_v[0] = 1'b0;
      m_v[1] = 1'b0;
      m_busy = 1'b0;
      m_free = cyc + 1;
    end else begin
      if (m_busy && cyc == m_resp + 1) begin
        m_v[m_port] = 1'b0;
        m_busy      = 1'b0;
        m_free      = cyc + 1;
      end
      if (!m_busy && cyc >= m_free && (m_v[0] || m_v[1])) begin
        m_port = m_v[0] ? 0 : 1;
        m_busy = 1'b1;
        m_resp = cyc + int'(L);
      end
      if (m_busy && cyc == m_resp) begin
        idx = int'(m_addr[m_port] % NB);
        if (m_wr[m_port]) begin
          m_mem[idx]   = m_data[m_port];
          m_known[idx] = 1'b1;
          m_exp_data   = m_data[m_port];
          m_exp_known  = 1'b1;
        end else begin
          m_exp_data  = m_mem[idx];
          m_exp_known = m_known[idx];
        end
        m_exp_port = m_port;
      end
      if (icache_req_valid && !m_v[0]) begin
        m_v[0] = 1'b1; m_wr[0] = 1'b0; m_addr[0] = icache_req_block_addr; m_data[0] = '0;
      end
      if (dcache_req_valid && !m_v[1]) begin
        m_v[1]    = 1'b1;
        m_wr[1]   = (dcache_req_type == WRITE);
        m_addr[1] = dcache_req_block_addr;
        m_data[1] = dcache_req_block_data;
      end
    end
  endtask

  // Continuous comparison of the main instance against the reference.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      model_step();
      #1;
      chk("mdl_i_ready", 64'(icache_req_ready), 64'(rst_aL && !m_v[0]));
      chk("mdl_d_ready", 64'(dcache_req_ready), 64'(rst_aL && !m_v[1]));
      chk("mdl_i_valid", 64'(icache_resp_valid), 64'(m_exp_port == 0));
      chk("mdl_d_valid", 64'(dcache_resp_valid), 64'(m_exp_port == 1));
      if (!(m_exp_port == 0 && !m_exp_known))
        chk("mdl_i_data", icache_resp_block_data, (m_exp_port == 0) ? m_exp_data : 64'h0);
      if (!(m_exp_port == 1 && !m_exp_known))
        chk("mdl_d_data", dcache_resp_block_data, (m_exp_port == 1) ? m_exp_data : 64'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // Main-instance dcache transaction; returns with the response cycle active.
  task automatic d_txn(input bit wr, input logic [31:0] a, input logic [63:0] wd,
                       input logic [63:0] ed, input string nm);
    int n;
    dcache_req_valid      = 1'b1;
    dcache_req_type       = wr ? WRITE : READ;
    dcache_req_block_addr = a;
    dcache_req_block_data = wd;
    @(posedge clk); #1;
    dcache_req_valid      = 1'b0;
    dcache_req_block_data = '0;
    n = 0;
    while (!dcache_resp_valid && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_lat"}, 64'(n), 64'(L + 1));
    chk({nm, "_data"}, dcache_resp_block_data, ed);
  endtask

  // Small-instance transaction on either port.
  task automatic s_txn(input bit ic, input bit wr, input logic [31:0] a,
                       input logic [63:0] wd, input logic [63:0] ed, input string nm);
    int n;
    if (ic) begin
      s_icache_req_valid      = 1'b1;
      s_icache_req_type       = READ;
      s_icache_req_block_addr = a;
    end else begin
      s_dcache_req_valid      = 1'b1;
      s_dcache_req_type       = wr ? WRITE : READ;
      s_dcache_req_block_addr = a;
      s_dcache_req_block_data = wd;
    end
    @(posedge clk); #1;
    s_icache_req_valid = 1'b0;
    s_dcache_req_valid = 1'b0;
    n = 0;
    while (!(ic ? s_icache_resp_valid : s_dcache_resp_valid) && n < 32) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_lat"}, 64'(n), 64'(SL + 1));
    chk({nm, "_data"}, ic ? s_icache_resp_block_data : s_dcache_resp_block_data, ed);
    chk({nm, "_other"}, 64'(ic ? s_dcache_resp_valid : s_icache_resp_valid), 64'(0));
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp;
  } txn_t;

  txn_t tbl [8];

  initial begin
    int ti, td1, td2, nresp, i_out, d_out;
    int i_req_n, d_req_n, i_resp_n, d_resp_n;
    bit ov, di, dd;
    logic [63:0] idat, d1dat, d2dat;

    tbl[0] = '{1'b1, 32'h0000_0005, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D};
    tbl[1] = '{1'b0, 32'h0000_0005, 64'h0,                 64'hDEADBEEF_CAFEF00D};
    tbl[2] = '{1'b1, 32'h0000_0007, 64'h0000_0000_0000_1234, 64'h0000_0000_0000_1234};
    tbl[3] = '{1'b1, 32'h0000_0009, 64'h0000_0000_0000_0055, 64'h0000_0000_0000_0055};
    tbl[4] = '{1'b0, 32'h0000_0407, 64'h0,                 64'h0000_0000_0000_1234};
    tbl[5] = '{1'b1, 32'h0000_03FF, 64'hA5A5_5A5A_0F0F_F0F0, 64'hA5A5_5A5A_0F0F_F0F0};
    tbl[6] = '{1'b0, 32'h0000_13FF, 64'h0,                 64'hA5A5_5A5A_0F0F_F0F0};
    tbl[7] = '{1'b0, 32'h0000_0009, 64'h0,                 64'h0000_0000_0000_0055};

    icache_req_valid = 1'b0; icache_req_type = READ; icache_req_block_addr = '0; icache_req_block_data = '0;
    dcache_req_valid = 1'b0; dcache_req_type = READ; dcache_req_block_addr = '0; dcache_req_block_data = '0;
    s_icache_req_valid = 1'b0; s_icache_req_type = READ; s_icache_req_block_addr = '0; s_icache_req_block_data = '0;
    s_dcache_req_valid = 1'b0; s_dcache_req_type = READ; s_dcache_req_block_addr = '0; s_dcache_req_block_data = '0;

    // Reset for three cycles
    rst_aL = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rst_i_ready",   64'(icache_req_ready),   64'(0));
      chk("rst_d_ready",   64'(dcache_req_ready),   64'(0));
      chk("rst_s_i_ready", 64'(s_icache_req_ready), 64'(0));
      chk("rst_s_d_ready", 64'(s_dcache_req_ready), 64'(0));
    end
    @(negedge clk);
    rst_aL = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_i_ready", 64'(icache_req_ready),  64'(1));
    chk("post_rst_d_ready", 64'(dcache_req_ready),  64'(1));
    chk("post_rst_i_valid", 64'(icache_resp_valid), 64'(0));
    chk("post_rst_d_valid", 64'(dcache_resp_valid), 64'(0));
    chk("post_rst_i_data",  icache_resp_block_data, 64'h0);
    chk("post_rst_d_data",  dcache_resp_block_data, 64'h0);
    chk("post_rst_s_ready", 64'({s_icache_req_ready, s_dcache_req_ready}), 64'(3));

    // Directed dcache table; each next request is issued in the previous RESP cycle
    for (int i = 0; i < 8; i++) begin
      d_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp, $sformatf("tbl%0d", i));
    end

    // Simultaneous icache READ 0x5 and dcache READ 0x7
    repeat (2) @(negedge clk);
    icache_req_valid = 1'b1; icache_req_block_addr = 32'h5;
    dcache_req_valid = 1'b1; dcache_req_type = READ; dcache_req_block_addr = 32'h7;
    @(posedge clk); #1;
    icache_req_valid = 1'b0; dcache_req_valid = 1'b0;
    ti = -1; td1 = -1; ov = 1'b0; idat = '0; d1dat = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (icache_resp_valid && dcache_resp_valid) ov = 1'b1;
      if (icache_resp_valid && ti < 0) begin ti = n; idat = icache_resp_block_data; end
      if (dcache_resp_valid && td1 < 0) begin td1 = n; d1dat = dcache_resp_block_data; end
    end
    chk("sim_i_lat",   64'(ti),  64'(L + 1));
    chk("sim_d_lat",   64'(td1), 64'(2 * L + 3));
    chk("sim_i_data",  idat,  64'hDEADBEEF_CAFEF00D);
    chk("sim_d_data",  d1dat, 64'h1234);
    chk("sim_overlap", 64'(ov), 64'(0));

    // Priority: icache arrives while dcache busy, newer dcache waits behind it
    @(negedge clk);
    dcache_req_valid = 1'b1; dcache_req_type = READ; dcache_req_block_addr = 32'h7;
    @(posedge clk); #1;
    dcache_req_valid = 1'b0;
    ti = -1; td1 = -1; td2 = -1; idat = '0; d1dat = '0; d2dat = '0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (n == 3)  begin icache_req_valid = 1'b1; icache_req_block_addr = 32'h5; end
      if (n == 12) begin dcache_req_valid = 1'b1; dcache_req_type = READ; dcache_req_block_addr = 32'h9; end
      @(posedge clk); #1;
      icache_req_valid = 1'b0; dcache_req_valid = 1'b0;
      if (icache_resp_valid && ti < 0) begin ti = n; idat = icache_resp_block_data; end
      if (dcache_resp_valid) begin
        if (td1 < 0) begin td1 = n; d1dat = dcache_resp_block_data; end
        else if (td2 < 0) begin td2 = n; d2dat = dcache_resp_block_data; end
      end
    end
    chk("pri_d1_lat",  64'(td1), 64'(11));
    chk("pri_i_lat",   64'(ti),  64'(23));
    chk("pri_d2_lat",  64'(td2), 64'(35));
    chk("pri_d1_data", d1dat, 64'h1234);
    chk("pri_i_data",  idat,  64'hDEADBEEF_CAFEF00D);
    chk("pri_d2_data", d2dat, 64'h55);

    // Reset while a dcache WRITE is in BUSY
    @(negedge clk);
    dcache_req_valid = 1'b1; dcache_req_type = WRITE;
    dcache_req_block_addr = 32'h9; dcache_req_block_data = 64'hAA;
    @(posedge clk); #1;
    dcache_req_valid = 1'b0; dcache_req_block_data = '0;
    nresp = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 5) rst_aL = 1'b0;
      if (n == 7) rst_aL = 1'b1;
      @(posedge clk); #1;
      if (dcache_resp_valid || icache_resp_valid) nresp++;
      if (n == 5) chk("rstmid_d_ready", 64'(dcache_req_ready), 64'(0));
    end
    chk("rstmid_noresp", 64'(nresp), 64'(0));
    d_txn(1'b0, 32'h9, 64'h0, 64'h55, "rstmid_read");

    // Small instance: single-cycle latency and 16-block aliasing
    s_txn(1'b0, 1'b1, 32'h05, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, "sm_w05");
    s_txn(1'b0, 1'b0, 32'h15, 64'h0, 64'h1111_2222_3333_4444, "sm_r15");
    s_txn(1'b1, 1'b0, 32'h25, 64'h0, 64'h1111_2222_3333_4444, "sm_ir25");
    s_txn(1'b0, 1'b1, 32'h1F, 64'h0000_BEEF_0000_BEEF, 64'h0000_BEEF_0000_BEEF, "sm_w1f");
    s_txn(1'b1, 1'b0, 32'h0F, 64'h0, 64'h0000_BEEF_0000_BEEF, "sm_irf");

    // Randomized traffic on the main instance, checked by the reference
    repeat (3) @(negedge clk);
    i_out = 0; d_out = 0; i_req_n = 0; d_req_n = 0; i_resp_n = 0; d_resp_n = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      di = (i_out == 0) && ($urandom_range(2) == 0);
      dd = (d_out == 0) && ($urandom_range(2) == 0);
      if (di) begin
        icache_req_valid      = 1'b1;
        icache_req_block_addr = 32'(($urandom_range(3) << 10) | $urandom_range(15));
      end
      if (dd) begin
        dcache_req_valid      = 1'b1;
        dcache_req_type       = ($urandom_range(1) == 1) ? WRITE : READ;
        dcache_req_block_addr = 32'(($urandom_range(3) << 10) | $urandom_range(15));
        dcache_req_block_data = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      icache_req_valid = 1'b0; dcache_req_valid = 1'b0;
      if (icache_resp_valid) begin i_out = 0; i_resp_n++; end
      if (dcache_resp_valid) begin d_out = 0; d_resp_n++; end
      if (di) begin i_out = 1; i_req_n++; end
      if (dd) begin d_out = 1; d_req_n++; end
    end
    for (int c = 0; c < 60 && (i_out != 0 || d_out != 0); c++) begin
      @(posedge clk); #1;
      if (icache_resp_valid) begin i_out = 0; i_resp_n++; end
      if (dcache_resp_valid) begin d_out = 0; d_resp_n++; end
    end
    chk("rnd_i_count", 64'(i_resp_n), 64'(i_req_n));
    chk("rnd_d_count", 64'(d_resp_n), 64'(d_req_n));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
